// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser.
// State encoding includes WAIT_SENSE, which only the JAM_DETECT_EN build uses.
package change_dispenser_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StSelect    = 3'd1,
        StEject     = 3'd2,
        StGap       = 3'd3,
        StFinish    = 3'd4,
        StWaitSense = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CoinNone = 2'd0,
        Coin1    = 2'd1,
        Coin2    = 2'd2,
        Coin5    = 2'd3
    } coin_e;

    localparam int unsigned COIN1_VAL = 1;
    localparam int unsigned COIN2_VAL = 2;
    localparam int unsigned COIN5_VAL = 5;

    // Face value of a selected coin; CoinNone is worth nothing.
    function automatic int unsigned coin_value(coin_e coin);
        int unsigned val;
        val = 0;
        case (coin)
            Coin1:   val = COIN1_VAL;
            Coin2:   val = COIN2_VAL;
            Coin5:   val = COIN5_VAL;
            default: val = 0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Controller/hopper-side signal bundle of the change dispenser.
// master = vending controller side, slave = dispenser side.
interface change_dispenser_if #(
    parameter int unsigned CREDIT_W = 8,
    parameter int unsigned CNT_W    = 4
);
    logic                start;
    logic [CREDIT_W-1:0] amount;
    logic                refill;
    logic                coin_seen;
    logic                busy;
    logic                done;
    logic [CREDIT_W-1:0] short_amt;
    logic                eject1;
    logic                eject2;
    logic                eject5;
    logic [CNT_W-1:0]    cnt1;
    logic [CNT_W-1:0]    cnt2;
    logic [CNT_W-1:0]    cnt5;
    logic                jam;

    modport master (
        output start, amount, refill, coin_seen,
        input  busy, done, short_amt, eject1, eject2, eject5, cnt1, cnt2, cnt5, jam
    );

    modport slave (
        input  start, amount, refill, coin_seen,
        output busy, done, short_amt, eject1, eject2, eject5, cnt1, cnt2, cnt5, jam
    );
endinterface

// File: rtl/change_dispenser_pulse_timer.sv
// Loadable down-counter with a zero flag; times solenoid pulses, gaps and sense windows.
module pulse_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;

    // Load wins; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin-return sequencer for the $1/$2/$5 hoppers.
// Optional feature macro: JAM_DETECT_EN (adds WAIT_SENSE state, coin sensing and sticky jam).
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned INIT_COUNT   = 8,
    parameter int unsigned PULSE_CYCLES = 10,
    parameter int unsigned GAP_CYCLES   = 10,
    parameter int unsigned JAM_CYCLES   = 20
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);
    localparam int unsigned TMR_MAX0 = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_MAX  = (TMR_MAX0 > JAM_CYCLES) ? TMR_MAX0 : JAM_CYCLES;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(INIT_COUNT);
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
`ifdef JAM_DETECT_EN
    localparam logic [TMR_W-1:0] JAM_LOAD   = TMR_W'(JAM_CYCLES - 1);
`endif

    state_e              r_state,     w_state_nxt;
    coin_e               r_coin,      w_coin_nxt;
    logic [CREDIT_W-1:0] r_remaining, w_remaining_nxt;
    logic [CREDIT_W-1:0] r_short,     w_short_nxt;
    logic [CNT_W-1:0]    r_cnt1,      w_cnt1_nxt;
    logic [CNT_W-1:0]    r_cnt2,      w_cnt2_nxt;
    logic [CNT_W-1:0]    r_cnt5,      w_cnt5_nxt;
`ifdef JAM_DETECT_EN
    logic                r_jam,       w_jam_nxt;
`else
    logic                w_unused_coin_seen;
`endif

    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_value;
    logic                w_tmr_zero;
    logic [CREDIT_W-1:0] w_coin_val;

    assign w_coin_val = CREDIT_W'(coin_value(r_coin));

    pulse_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_zero  (w_tmr_zero)
    );

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_coin      <= CoinNone;
            r_remaining <= '0;
            r_short     <= '0;
            r_cnt1      <= CNT_INIT;
            r_cnt2      <= CNT_INIT;
            r_cnt5      <= CNT_INIT;
`ifdef JAM_DETECT_EN
            r_jam       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_coin      <= w_coin_nxt;
            r_remaining <= w_remaining_nxt;
            r_short     <= w_short_nxt;
            r_cnt1      <= w_cnt1_nxt;
            r_cnt2      <= w_cnt2_nxt;
            r_cnt5      <= w_cnt5_nxt;
`ifdef JAM_DETECT_EN
            r_jam       <= w_jam_nxt;
`endif
        end
    end

    // Next-state logic: greedy selection, pulse/gap timing, hopper and remainder bookkeeping.
    always_comb begin
        w_state_nxt     = r_state;
        w_coin_nxt      = r_coin;
        w_remaining_nxt = r_remaining;
        w_short_nxt     = r_short;
        w_cnt1_nxt      = r_cnt1;
        w_cnt2_nxt      = r_cnt2;
        w_cnt5_nxt      = r_cnt5;
        w_tmr_load      = 1'b0;
        w_tmr_value     = '0;
`ifdef JAM_DETECT_EN
        w_jam_nxt       = r_jam;
`endif

        case (r_state)
            StIdle: begin
                // Refill lands on the same edge as an accepted start, so SELECT sees full hoppers.
                if (bus.refill) begin
                    w_cnt1_nxt = CNT_INIT;
                    w_cnt2_nxt = CNT_INIT;
                    w_cnt5_nxt = CNT_INIT;
                end
                if (bus.start) begin
                    w_remaining_nxt = bus.amount;
                    w_short_nxt     = '0;
                    w_state_nxt     = StSelect;
`ifdef JAM_DETECT_EN
                    if (r_jam) begin
                        w_short_nxt = bus.amount;
                        w_state_nxt = StFinish;
                    end
`endif
                end
            end

            StSelect: begin
                if (r_remaining >= CREDIT_W'(COIN5_VAL) && r_cnt5 != '0) begin
                    w_coin_nxt = Coin5;
                end else if (r_remaining >= CREDIT_W'(COIN2_VAL) && r_cnt2 != '0) begin
                    w_coin_nxt = Coin2;
                end else if (r_remaining >= CREDIT_W'(COIN1_VAL) && r_cnt1 != '0) begin
                    w_coin_nxt = Coin1;
                end else begin
                    w_coin_nxt = CoinNone;
                end

                if (w_coin_nxt == CoinNone) begin
                    w_short_nxt = r_remaining;
                    w_state_nxt = StFinish;
                end else begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = PULSE_LOAD;
                    w_state_nxt = StEject;
                end
            end

            StEject: begin
                if (w_tmr_zero) begin
                    // Selection guaranteed a non-zero count, so this never underflows.
                    case (r_coin)
                        Coin1:   w_cnt1_nxt = r_cnt1 - CNT_W'(1);
                        Coin2:   w_cnt2_nxt = r_cnt2 - CNT_W'(1);
                        Coin5:   w_cnt5_nxt = r_cnt5 - CNT_W'(1);
                        default: ;
                    endcase
                    w_tmr_load = 1'b1;
`ifdef JAM_DETECT_EN
                    w_tmr_value = JAM_LOAD;
                    w_state_nxt = StWaitSense;
`else
                    w_remaining_nxt = r_remaining - w_coin_val;
                    w_tmr_value     = GAP_LOAD;
                    w_state_nxt     = StGap;
`endif
                end
            end

`ifdef JAM_DETECT_EN
            StWaitSense: begin
                // A coin sensed in the last window cycle still counts as paid.
                if (bus.coin_seen) begin
                    w_remaining_nxt = r_remaining - w_coin_val;
                    w_tmr_load      = 1'b1;
                    w_tmr_value     = GAP_LOAD;
                    w_state_nxt     = StGap;
                end else if (w_tmr_zero) begin
                    w_jam_nxt   = 1'b1;
                    w_short_nxt = r_remaining;
                    w_state_nxt = StFinish;
                end
            end
`endif

            StGap: begin
                if (w_tmr_zero) begin
                    w_state_nxt = StSelect;
                end
            end

            StFinish: begin
                w_coin_nxt  = CoinNone;
                w_state_nxt = StIdle;
            end

            default: begin
                w_coin_nxt  = CoinNone;
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Outputs decoded straight from registered state.
    always_comb begin
        bus.busy      = (r_state == StSelect) || (r_state == StEject) ||
                        (r_state == StGap)    || (r_state == StWaitSense);
        bus.done      = (r_state == StFinish);
        bus.eject1    = (r_state == StEject) && (r_coin == Coin1);
        bus.eject2    = (r_state == StEject) && (r_coin == Coin2);
        bus.eject5    = (r_state == StEject) && (r_coin == Coin5);
        bus.short_amt = r_short;
        bus.cnt1      = r_cnt1;
        bus.cnt2      = r_cnt2;
        bus.cnt5      = r_cnt5;
`ifdef JAM_DETECT_EN
        bus.jam       = r_jam;
`else
        bus.jam       = 1'b0;
`endif
    end

`ifndef JAM_DETECT_EN
    assign w_unused_coin_seen = bus.coin_seen;
`endif

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequencer for the coin-return hoppers ($1, $2, $5). Sits between the vending controller and the hopper solenoids.
- On a `start` pulse it takes the controller's change-due amount and dispenses it greedily, largest coin first, one solenoid pulse at a time.
- Tracks per-hopper coin counts and reports any amount it could not pay out.

Parameters:
- CREDIT_W, 8, width of amount/remaining/short values
- CNT_W, 4, width of each hopper coin counter
- INIT_COUNT, 8, hopper count loaded at reset and on refill
- PULSE_CYCLES, 10, solenoid on-time per coin (clk cycles, >=1)
- GAP_CYCLES, 10, all-solenoids-off gap between coins (clk cycles, >=1)
- JAM_CYCLES, 20, coin-sense timeout (used only with JAM_DETECT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- start  in  1  one-cycle request to dispense `amount`
- amount  in  CREDIT_W  change to pay, sampled when `start` is accepted
- refill  in  1  one-cycle pulse: reload all hopper counts to INIT_COUNT
- coin_seen  in  1  exit-chute coin sensor pulse (JAM_DETECT_EN only, else ignored)
- busy  out  1  high from accepted `start` until `done`
- done  out  1  one-cycle completion pulse
- short_amt  out  CREDIT_W  undispensed remainder; valid with `done`, held until next accept
- eject1 / eject2 / eject5  out  1 each  solenoid drives, at most one high at a time
- cnt1 / cnt2 / cnt5  out  CNT_W each  current hopper counts
- jam  out  1  sticky jam fault (JAM_DETECT_EN only, else constant 0)

Behaviour:
- Reset values:
  - state IDLE
  - busy = done = 0, all eject* = 0
  - short_amt = 0, remaining = 0
  - cnt* = INIT_COUNT, jam = 0
- States: IDLE, SELECT, EJECT, GAP, FINISH.
- IDLE
  - `start` = 1 latches `amount` into `remaining`, sets busy, goes to SELECT next cycle.
  - `start` is ignored in every other state.
- SELECT (one cycle). Priority order:
  1. remaining >= 5 and cnt5 != 0 → coin 5
  2. else remaining >= 2 and cnt2 != 0 → coin 2
  3. else remaining >= 1 and cnt1 != 0 → coin 1
  4. else → FINISH with short_amt = remaining (0 if fully paid)
- EJECT
  - Selected eject* is high for exactly PULSE_CYCLES cycles.
  - On the final cycle: that hopper count decrements by 1 and `remaining` decrements by the coin value. Go to GAP.
- GAP
  - All eject* low for GAP_CYCLES cycles, then SELECT.
- FINISH
  - done = 1 for one cycle, busy cleared in the same cycle, then IDLE.
- Latency for amount = 0: start accepted at edge N → SELECT at N+1 → done high during cycle N+2.
- Per-coin period = 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- Counter and arithmetic rules:
  - Hopper counts never underflow; a hopper is never selected at 0.
  - `remaining` never goes negative; it is subtracted only after a compare guarantees remaining >= coin value.
- refill
  - Honoured in IDLE only (ignored while busy; the controller retries).
  - If refill and start arrive in the same IDLE cycle, counts reload and the start is also accepted. SELECT sees the reloaded counts.
- Reset mid-operation: the next edge forces IDLE, all eject* low and counts back to INIT_COUNT. No done pulse is generated.
- An empty hopper is skipped and a smaller coin is used. Example: remaining = 5 with cnt5 = 0 pays 2 + 2 + 1.

Optional Feature:
- Macro: JAM_DETECT_EN
- With the macro, after each EJECT an extra WAIT_SENSE state runs:
  - coin_seen within JAM_CYCLES cycles → GAP.
  - Timeout → jam = 1 (sticky until reset), coin treated as not paid (count still decremented, remaining unchanged), then FINISH with short_amt = remaining.
- A new start while jam = 1 finishes immediately with short_amt = amount.
- Without the macro: no WAIT_SENSE state, coin_seen unused, jam tied 0.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=0, SELECT=1, EJECT=2, GAP=3, FINISH=4, WAIT_SENSE=5)
  - coin value constants (1, 2, 5)
  - coin-select encoding (NONE/C1/C2/C5)
- Sub-module: `pulse_timer` — loadable down-counter with a `zero` flag, shared by EJECT, GAP and WAIT_SENSE.

Test Plan (PULSE_CYCLES = GAP_CYCLES = 2, INIT_COUNT = 8):
- Reset then start, amount = 0 → done at start + 2 cycles, short_amt = 0, no eject activity, busy high for 1 cycle.
- amount = 8 → eject5 once, then eject2 once, then eject1 once, each high for exactly 2 cycles and never overlapping; done with short_amt = 0; cnt5 = cnt2 = cnt1 = 7.
- Drain cnt5 to 0 via 8 × amount = 5, then amount = 5 → eject2, eject2, eject1; short_amt = 0.
- All counts 0 (drain each hopper), amount = 3 → no ejects, done with short_amt = 3; then refill, amount = 3 → eject2, eject1, short_amt = 0.
- start pulsed again mid-dispense and refill pulsed while busy → both ignored; counts and the first transaction are unaffected.
- Reset (rst = 0) during eject5 high → eject5 = 0 next edge, busy = 0, cnt5 = 8, no done pulse. With JAM_DETECT_EN: coin_seen withheld → jam = 1 after 20 cycles, short_amt = amount − coins sensed.
